bitrev_buffer: RTL

Parametrised bit-reversal reorder buffer for FFT output staging. It captures one frame of N = 2**LOG2_N samples in natural order and replays them one per read pulse. Replay order is bit-reversed or natural, selected per frame. It owns its own post-frame flush and re-arm sequence, so the host never drives an internal reset. It sits between the transform core and the host readout port.

---
 rtl/bitrev_pkg.sv | 39 +++
 rtl/bitrev_mem.sv | 31 +++
 rtl/bitrev_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared types and helpers for the bit-reversal reorder buffer.
//   state_t   - controller states (LOAD, READY, FLUSH)
//   cnt_width - bits needed to count 0..max_count, never less than 1
//   bitrev    - reverse the low 'width' bits of an index
package bitrev_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Widest index the bitrev helper handles.
  localparam int MAX_IDX_W = 32;

  function automatic int frame_len(input int log2_n);
    return 1 << log2_n;
  endfunction

  // A count of zero would otherwise give a zero-width counter.
  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] idx,
                                                  input int width);
    logic [MAX_IDX_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_IDX_W; i++) begin
      if (i < width) begin
        res[5'(width - 1 - i)] = idx[5'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bitrev_mem.sv
// bitrev_mem: 2**ADDR_W x DATA_W register file.
//   clk   - write clock
//   we    - write enable, data captured on rising clk
//   waddr - write address
//   wdata - write data
//   raddr - combinational read address
//   rdata - combinational read data
// Contents are deliberately not reset; the owner gates the read data.
module bitrev_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bitrev_buffer.sv
// bitrev_buffer: captures one frame of N = 2**LOG2_N samples in natural order
// and replays them one per read rising edge, bit-reversed or natural.
//   clk          - clock, all logic on rising edge
//   reset        - synchronous active-high reset
//   din_i        - input sample
//   start_flag_i - write strobe, one sample per high cycle in LOAD
//   rev_mode_i   - replay order, captured with the last write of a frame
//   read         - read request level; each 0->1 transition pops one sample
//   dout_o       - current replay sample, 0 outside READY
//   done_flag_o  - frame available (READY)
//   rd_idx_o     - pops taken in the current frame
//   busy_o       - post-frame flush in progress
//   overflow_o   - sticky, strobe seen outside LOAD
module bitrev_buffer
  import bitrev_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LOG2_N       = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din_i,
  input  logic              start_flag_i,
  input  logic              rev_mode_i,
  input  logic              read,
  output logic [DATA_W-1:0] dout_o,
  output logic              done_flag_o,
  output logic [LOG2_N-1:0] rd_idx_o,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam logic [LOG2_N-1:0] LAST_IDX = '1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t            state, state_nxt;
  logic [LOG2_N-1:0] wr_cnt, rd_cnt, rd_addr;
  logic [FW-1:0]     flush_cnt;
  logic              read_q, mode_q, overflow_q;
  logic              wr_en, pop;
  logic [DATA_W-1:0] rd_data;

  // Reset also blocks the write so a strobe in the reset cycle is dropped.
  bitrev_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_N)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (wr_cnt),
    .wdata (din_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rd_addr = mode_q ? LOG2_N'(bitrev(MAX_IDX_W'(rd_cnt), LOG2_N)) : rd_cnt;

  // Edge detect against the previous cycle's level so a held read pops once.
  assign pop = read & ~read_q;

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    done_flag_o = 1'b0;
    busy_o      = 1'b0;
    dout_o      = '0;
    case (state)
      LOAD: begin
        wr_en = start_flag_i;
        if (start_flag_i && wr_cnt == LAST_IDX) begin
          state_nxt = READY;
        end
      end
      READY: begin
        done_flag_o = 1'b1;
        dout_o      = rd_data;
        if (pop && rd_cnt == LAST_IDX) begin
          state_nxt = (FLUSH_CYCLES == 0) ? LOAD : FLUSH;
        end
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Counters wrap naturally at N-1, which is exactly the end-of-frame clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      flush_cnt  <= '0;
      read_q     <= 1'b0;
      mode_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      read_q <= read;
      if (start_flag_i && state != LOAD) begin
        overflow_q <= 1'b1;
      end
      case (state)
        LOAD: begin
          if (start_flag_i) begin
            wr_cnt <= wr_cnt + LOG2_N'(1);
            if (wr_cnt == LAST_IDX) begin
              rd_cnt <= '0;
              mode_q <= rev_mode_i;
            end
          end
        end
        READY: begin
          if (pop) begin
            rd_cnt <= rd_cnt + LOG2_N'(1);
          end
        end
        FLUSH: begin
          flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + FW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_idx_o   = rd_cnt;
  assign overflow_o = overflow_q;

endmodule
